// File: rtl/tm_slv_reg.sv
// tm_slv_reg: serial telemetry frame receiver and slave register bank.
// Hunts the tmdata bit stream for a 32-bit sync word, then deserializes
// FRAME_WORDS data words (MSB first) into reg0..reg63.
// Optional feature macro: TM_REG_CLEAR_EN. When it is defined, all registers
// clear on the sync-match edge.
module tm_slv_reg #(
    parameter logic [31:0] SYNC_WORD   = 32'hF9A42BB1,
    parameter int          FRAME_WORDS = 64
) (
    input  logic        tmclk,
    input  logic        reset,
    input  logic        tmdata,
    output logic [31:0] reg0,  reg1,  reg2,  reg3,  reg4,  reg5,  reg6,  reg7,
    output logic [31:0] reg8,  reg9,  reg10, reg11, reg12, reg13, reg14, reg15,
    output logic [31:0] reg16, reg17, reg18, reg19, reg20, reg21, reg22, reg23,
    output logic [31:0] reg24, reg25, reg26, reg27, reg28, reg29, reg30, reg31,
    output logic [31:0] reg32, reg33, reg34, reg35, reg36, reg37, reg38, reg39,
    output logic [31:0] reg40, reg41, reg42, reg43, reg44, reg45, reg46, reg47,
    output logic [31:0] reg48, reg49, reg50, reg51, reg52, reg53, reg54, reg55,
    output logic [31:0] reg56, reg57, reg58, reg59, reg60, reg61, reg62, reg63,
    output logic        fr_sync,
    output logic        load
);

    typedef enum logic {
        HUNT = 1'b0,
        RECV = 1'b1
    } state_t;

    // Index of the final word of a frame; the frame ends after it is written.
    localparam logic [5:0] LAST_IDX = 6'(FRAME_WORDS - 1);

    state_t      state_r;
    state_t      state_nxt_s;
    logic [31:0] sr_r;
    logic [31:0] sr_nxt_s;
    logic [4:0]  bit_cnt_r;
    logic [5:0]  word_idx_r;
    logic        match_s;
    logic        word_done_s;
    logic        fr_sync_r;
    logic        load_r;
    logic [31:0] regs_r [64];

    // Next-state and per-edge control decode.
    always_comb begin
        state_nxt_s = state_r;
        match_s     = 1'b0;
        word_done_s = 1'b0;
        sr_nxt_s    = {sr_r[30:0], tmdata};
        case (state_r)
            HUNT: begin
                if (sr_nxt_s == SYNC_WORD) begin
                    match_s     = 1'b1;
                    state_nxt_s = RECV;
                end else begin
                    state_nxt_s = HUNT;
                end
            end
            RECV: begin
                if (bit_cnt_r == 5'd31) begin
                    word_done_s = 1'b1;
                    if (word_idx_r == LAST_IDX) begin
                        state_nxt_s = HUNT;
                    end else begin
                        state_nxt_s = RECV;
                    end
                end else begin
                    state_nxt_s = RECV;
                end
            end
            default: begin
                state_nxt_s = HUNT;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge tmclk or negedge reset) begin
        if (!reset) begin
            state_r <= HUNT;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Shift register, bit/word counters and the registered pulse outputs.
    always_ff @(posedge tmclk or negedge reset) begin
        if (!reset) begin
            sr_r       <= 32'h0000_0000;
            bit_cnt_r  <= 5'd0;
            word_idx_r <= 6'd0;
            fr_sync_r  <= 1'b0;
            load_r     <= 1'b0;
        end else begin
            sr_r      <= sr_nxt_s;
            fr_sync_r <= match_s;
            load_r    <= word_done_s;
            if (match_s) begin
                bit_cnt_r  <= 5'd0;
                word_idx_r <= 6'd0;
            end else begin
                // Counter wraps 31 -> 0 so it is already 0 when back in HUNT.
                if (state_r == RECV) begin
                    bit_cnt_r <= bit_cnt_r + 5'd1;
                end
                if (word_done_s) begin
                    word_idx_r <= word_idx_r + 6'd1;
                end
            end
        end
    end

    // Register bank: write the completed word into its slot.
    always_ff @(posedge tmclk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 64; i++) begin
                regs_r[i] <= 32'h0000_0000;
            end
        end else begin
            for (int i = 0; i < 64; i++) begin
`ifdef TM_REG_CLEAR_EN
                if (match_s) begin
                    regs_r[i] <= 32'h0000_0000;
                end else
`endif
                if (word_done_s && (word_idx_r == 6'(i))) begin
                    regs_r[i] <= sr_nxt_s;
                end
            end
        end
    end

    assign fr_sync = fr_sync_r;
    assign load    = load_r;

    assign reg0  = regs_r[0];  assign reg1  = regs_r[1];  assign reg2  = regs_r[2];  assign reg3  = regs_r[3];
    assign reg4  = regs_r[4];  assign reg5  = regs_r[5];  assign reg6  = regs_r[6];  assign reg7  = regs_r[7];
    assign reg8  = regs_r[8];  assign reg9  = regs_r[9];  assign reg10 = regs_r[10]; assign reg11 = regs_r[11];
    assign reg12 = regs_r[12]; assign reg13 = regs_r[13]; assign reg14 = regs_r[14]; assign reg15 = regs_r[15];
    assign reg16 = regs_r[16]; assign reg17 = regs_r[17]; assign reg18 = regs_r[18]; assign reg19 = regs_r[19];
    assign reg20 = regs_r[20]; assign reg21 = regs_r[21]; assign reg22 = regs_r[22]; assign reg23 = regs_r[23];
    assign reg24 = regs_r[24]; assign reg25 = regs_r[25]; assign reg26 = regs_r[26]; assign reg27 = regs_r[27];
    assign reg28 = regs_r[28]; assign reg29 = regs_r[29]; assign reg30 = regs_r[30]; assign reg31 = regs_r[31];
    assign reg32 = regs_r[32]; assign reg33 = regs_r[33]; assign reg34 = regs_r[34]; assign reg35 = regs_r[35];
    assign reg36 = regs_r[36]; assign reg37 = regs_r[37]; assign reg38 = regs_r[38]; assign reg39 = regs_r[39];
    assign reg40 = regs_r[40]; assign reg41 = regs_r[41]; assign reg42 = regs_r[42]; assign reg43 = regs_r[43];
    assign reg44 = regs_r[44]; assign reg45 = regs_r[45]; assign reg46 = regs_r[46]; assign reg47 = regs_r[47];
    assign reg48 = regs_r[48]; assign reg49 = regs_r[49]; assign reg50 = regs_r[50]; assign reg51 = regs_r[51];
    assign reg52 = regs_r[52]; assign reg53 = regs_r[53]; assign reg54 = regs_r[54]; assign reg55 = regs_r[55];
    assign reg56 = regs_r[56]; assign reg57 = regs_r[57]; assign reg58 = regs_r[58]; assign reg59 = regs_r[59];
    assign reg60 = regs_r[60]; assign reg61 = regs_r[61]; assign reg62 = regs_r[62]; assign reg63 = regs_r[63];

endmodule

// File: tb/tb_tm_slv_reg.sv
// tb_tm_slv_reg: self-checking bench for tm_slv_reg. A bit-level reference
// model tracks the last 32 received bits and how many frame bits remain,
// predicting fr_sync, load and the register bank contents.
module tb_tm_slv_reg;

    localparam logic [31:0] SYNC = 32'hF9A42BB1;
    localparam int          FW   = 64;

    logic        tmclk  = 1'b0;
    logic        reset  = 1'b0;
    logic        tmdata = 1'b0;
    logic [31:0] r [64];
    logic        fr_sync;
    logic        load;

    int n_vec = 0;
    int n_err = 0;
    int n_fr  = 0;
    int n_ld  = 0;

    // Reference model state.
    logic [31:0] m_win;
    int          m_rem;
    int          m_idx;
    logic        m_fr;
    logic        m_ld;
    logic [31:0] m_regs [64];

    logic [31:0] sw;
    logic [31:0] words [64];

    tm_slv_reg #(.SYNC_WORD(SYNC), .FRAME_WORDS(FW)) dut (
        .tmclk(tmclk), .reset(reset), .tmdata(tmdata),
        .reg0(r[0]),   .reg1(r[1]),   .reg2(r[2]),   .reg3(r[3]),
        .reg4(r[4]),   .reg5(r[5]),   .reg6(r[6]),   .reg7(r[7]),
        .reg8(r[8]),   .reg9(r[9]),   .reg10(r[10]), .reg11(r[11]),
        .reg12(r[12]), .reg13(r[13]), .reg14(r[14]), .reg15(r[15]),
        .reg16(r[16]), .reg17(r[17]), .reg18(r[18]), .reg19(r[19]),
        .reg20(r[20]), .reg21(r[21]), .reg22(r[22]), .reg23(r[23]),
        .reg24(r[24]), .reg25(r[25]), .reg26(r[26]), .reg27(r[27]),
        .reg28(r[28]), .reg29(r[29]), .reg30(r[30]), .reg31(r[31]),
        .reg32(r[32]), .reg33(r[33]), .reg34(r[34]), .reg35(r[35]),
        .reg36(r[36]), .reg37(r[37]), .reg38(r[38]), .reg39(r[39]),
        .reg40(r[40]), .reg41(r[41]), .reg42(r[42]), .reg43(r[43]),
        .reg44(r[44]), .reg45(r[45]), .reg46(r[46]), .reg47(r[47]),
        .reg48(r[48]), .reg49(r[49]), .reg50(r[50]), .reg51(r[51]),
        .reg52(r[52]), .reg53(r[53]), .reg54(r[54]), .reg55(r[55]),
        .reg56(r[56]), .reg57(r[57]), .reg58(r[58]), .reg59(r[59]),
        .reg60(r[60]), .reg61(r[61]), .reg62(r[62]), .reg63(r[63]),
        .fr_sync(fr_sync), .load(load)
    );

    // Bit clock.
    initial forever #5 tmclk = ~tmclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_win = 32'h0;
        m_rem = 0;
        m_fr  = 1'b0;
        m_ld  = 1'b0;
        for (int i = 0; i < 64; i++) m_regs[i] = 32'h0;
    endtask

    // Predict the effect of one rising edge that samples bit b.
    task automatic model_step(input logic b);
        logic [31:0] nw;
        int got;
        nw   = {m_win[30:0], b};
        m_fr = 1'b0;
        m_ld = 1'b0;
        if (m_rem == 0) begin
            if (nw == SYNC) begin
                m_fr  = 1'b1;
                m_rem = 32 * FW;
`ifdef TM_REG_CLEAR_EN
                for (int i = 0; i < 64; i++) m_regs[i] = 32'h0;
`endif
            end
        end else begin
            m_rem = m_rem - 1;
            got   = 32 * FW - m_rem;
            if (got % 32 == 0) begin
                m_idx         = got / 32 - 1;
                m_regs[m_idx] = nw;
                m_ld          = 1'b1;
            end
        end
        m_win = nw;
    endtask

    // Drive one bit, clock it, then check the pulse outputs.
    task automatic tick(input logic b);
        @(negedge tmclk);
        tmdata = b;
        if (reset) begin
            model_step(b);
        end else begin
            m_fr = 1'b0;
            m_ld = 1'b0;
        end
        @(posedge tmclk);
        #1;
        chk("fr_sync", 32'(fr_sync), 32'(m_fr));
        chk("load", 32'(load), 32'(m_ld));
        if (m_ld) chk($sformatf("load_word%0d", m_idx), r[m_idx], m_regs[m_idx]);
        if (fr_sync) n_fr++;
        if (load) n_ld++;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 31; i >= 0; i--) tick(w[i]);
    endtask

    task automatic check_all(input string tag);
        for (int i = 0; i < 64; i++) chk($sformatf("%s_reg%0d", tag, i), r[i], m_regs[i]);
    endtask

    initial begin
        sw = SYNC;
        model_reset();

        // Reset held with random data.
        reset = 1'b0;
        for (int i = 0; i < 10; i++) tick(1'($urandom_range(0, 1)));
        check_all("rst");

        // Release with idle zeros.
        @(negedge tmclk);
        reset = 1'b1;
        for (int i = 0; i < 40; i++) tick(1'b0);
        check_all("idle");
        chk("idle_fr_count", 32'(n_fr), 32'd0);

        // Near-miss patterns.
        send_word(32'hF9A42BB0);
        for (int i = 31; i >= 1; i--) tick(sw[i]);
        tick(1'b0);
        for (int i = 0; i < 8; i++) tick(1'b0);
        chk("near_fr_count", 32'(n_fr), 32'd0);
        chk("near_ld_count", 32'(n_ld), 32'd0);
        check_all("near");

        // First full frame, sync embedded as word 3, word 63 primes a back-to-back sync.
        for (int i = 0; i < 64; i++) words[i] = $urandom;
        words[0]  = 32'h00ABABAB;
        words[1]  = 32'h00ABABAC;
        words[3]  = SYNC;
        words[63] = {1'b0, sw[31:1]};
        send_word(SYNC);
        for (int i = 0; i < 64; i++) send_word(words[i]);
        chk("f1_reg0", r[0], 32'h00ABABAB);
        chk("f1_reg1", r[1], 32'h00ABABAC);
        chk("f1_reg3", r[3], 32'hF9A42BB1);
        chk("f1_fr_count", 32'(n_fr), 32'd1);
        chk("f1_ld_count", 32'(n_ld), 32'd64);
        check_all("f1");

        // Sync completes on the very next edge after the last word.
        tick(sw[0]);
        chk("f2_fr_count", 32'(n_fr), 32'd2);
        send_word(32'h12345678);
        chk("f2_reg0", r[0], 32'h12345678);
`ifdef TM_REG_CLEAR_EN
        chk("f2_reg63", r[63], 32'h0);
`else
        chk("f2_reg63", r[63], {1'b0, sw[31:1]});
`endif
        check_all("f2a");
        for (int i = 1; i < 64; i++) send_word($urandom);
        chk("f2_ld_count", 32'(n_ld), 32'd128);
        check_all("f2b");

        // Reset in the middle of word 5.
        send_word(SYNC);
        for (int i = 0; i < 5; i++) send_word($urandom);
        for (int i = 0; i < 17; i++) tick(1'($urandom_range(0, 1)));
        @(negedge tmclk);
        reset = 1'b0;
        model_reset();
        #1;
        check_all("midrst");
        chk("midrst_fr", 32'(fr_sync), 32'd0);
        chk("midrst_ld", 32'(load), 32'd0);
        for (int i = 0; i < 3; i++) tick(1'($urandom_range(0, 1)));
        @(negedge tmclk);
        reset = 1'b1;
        for (int i = 0; i < 4; i++) tick(1'b0);
        send_word(SYNC);
        for (int i = 0; i < 3; i++) send_word($urandom);
        for (int i = 0; i < 4; i++) tick(1'b0);
        check_all("post");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/tm_slv_reg.md
# tm_slv_reg

Serial telemetry frame receiver and slave register bank. It hunts the single-bit `tmdata` stream for a 32-bit frame-sync word, then deserializes the following 32-bit data words MSB-first into 64 parallel output registers `reg0`–`reg63`. It sits behind the telemetry serial link and feeds downstream logic that reads decoded telemetry words. It flags frame lock with `fr_sync` and flags each completed word with `load`.

## Interface
- `SYNC_WORD`, default 32'hF9A42BB1: frame-sync pattern, received MSB first.
- `FRAME_WORDS`, default 64: data words per frame, legal range 1–64. Registers at or above this index are never written.
- `tmclk` in 1: telemetry bit clock. All logic is on the rising edge.
- `reset` in 1: asynchronous, active-low reset. Reset is applied while `reset` = 0.
- `tmdata` in 1: serial data, sampled on the rising edge of `tmclk`.
- `reg0` … `reg63` out 32 each: received data words. `regN` holds word N of the frame, counted from 0 after the sync word.
- `fr_sync` out 1: one-cycle pulse when the sync word is detected.
- `load` out 1: one-cycle pulse when a data word has been written to its register.

## Operation
- The 32-bit shift register `sr` takes `{sr[30:0], tmdata}` on every edge. The first bit received ends up in bit 31.
- State HUNT:
  - On each edge, compare `{sr[30:0], tmdata}` against `SYNC_WORD` as a full 32-bit exact match.
  - On a match: register `fr_sync` = 1 for the next cycle, clear the bit counter and word index, and go to RECV.
- State RECV:
  - The 5-bit bit counter counts 0..31.
  - On the edge where the counter = 31, write `{sr[30:0], tmdata}` to `reg[word_idx]`, register `load` = 1 for the next cycle, and increment `word_idx`.
  - After word `FRAME_WORDS-1` is written, return to HUNT. A new sync can be detected on the very next edge.
- Sync detection is disabled in RECV. A pattern equal to `SYNC_WORD` inside the data is stored as data.
- Registers hold their value until overwritten or reset.
- There is no handshake and no backpressure. `load` and `fr_sync` are never asserted in the same cycle.

## Timing
- Reset: all `regN` = 0, `fr_sync` = 0, `load` = 0, `sr` = 0, state = HUNT, counters = 0.
- An asynchronous reset assertion in the middle of a frame aborts it immediately. Words already written are cleared to 0.
- `fr_sync` goes high in the cycle after the edge that samples the last (LSB) sync bit, for exactly 1 cycle.
- The first data bit (word 0, bit 31) is sampled on the first edge after the sync-match edge.
- Word k completes on the edge 32·(k+1) after the sync-match edge. On that same edge, `reg[k]` updates and `load` is raised. Both are visible together for 1 cycle.
- A full frame takes 32 + 32·`FRAME_WORDS` bit clocks.
- Outputs are registered and have no combinational path from `tmdata`.

## Configuration
- `TM_REG_CLEAR_EN` defined:
  - On the sync-match edge, all 64 registers clear to 0, in the same cycle `fr_sync` is raised.
  - Words not yet received in the current frame therefore read 0.
- `TM_REG_CLEAR_EN` undefined:
  - Registers retain values from the previous frame until overwritten.

## Test plan
- Reset: hold `reset` = 0 for 10 clocks with random `tmdata` → all `regN` = 0, `fr_sync` = 0, `load` = 0 throughout. After release with `tmdata` = 0, nothing asserts.
- Basic frame: shift in 0xF9A42BB1, then 0x00ABABAB, 0x00ABABAC, … →
  - `fr_sync` pulses once.
  - `reg0` = 0x00ABABAB and `reg1` = 0x00ABABAC.
  - Each `load` pulse occurs exactly 32 clocks after the previous one.
- Near-miss sync 0xF9A42BB0, or a 31-bit prefix of the sync word followed by a 0 bit → no `fr_sync`, no `load`, registers unchanged.
- Sync pattern inside data: word 3 = 0xF9A42BB1 → `reg3` = 0xF9A42BB1, no extra `fr_sync`, and word 4 lands in `reg4`.
- Full frame wrap-around:
  - Send 64 words, then a second sync plus 1 word 0x12345678.
  - Expect 64 `load` pulses, then `fr_sync`, then `reg0` = 0x12345678.
  - `reg63` keeps the first-frame value without `TM_REG_CLEAR_EN`, and reads 0 with it.
- Reset in the middle of a frame: assert `reset` during bit 17 of word 5 → all registers 0 at once, state HUNT. The next valid sync plus words are received correctly from `reg0`.
